instr_decode_buffer: RTL and testbench
======================================

# instr_decode_buffer

Two-entry instruction buffer between instruction fetch and the decode/execute stage. It accepts 16-bit instructions and their PC from fetch with a valid/ready handshake and holds them in order. It presents the head entry split into register fields and the 4-bit immediate, which goes straight to the sign extender's unextended input. It supports pipeline flush and latches a processor halt when a HALT instruction is consumed.

## Interface
- INSTR_W, 16, instruction width; field split below fixed for 16
- PC_W, 16, program counter width

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  fetch presents an instruction
- in_instr  in  INSTR_W  instruction word
- in_pc  in  PC_W  PC of in_instr
- in_ready  out  1  buffer can accept this cycle
- out_valid  out  1  head entry valid
- out_ready  in  1  decode consumes head this cycle
- flush  in  1  synchronous discard of all entries
- out_pc  out  PC_W  PC of head entry
- opcode  out  4  head instr[15:12]
- rd  out  4  head instr[11:8]
- rs  out  4  head instr[7:4]
- rt  out  4  head instr[3:0]
- imm4  out  4  head instr[3:0], to sign extender
- count  out  2  occupied entries, 0..2
- halted  out  1  HALT (opcode 4'hF) has been consumed

## Operation
- Storage: 2 entries of {instr, pc}; write pointer, read pointer (1 bit each), count register.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != 2) & ~halted. Registered state only; no combinational path from out_ready to in_ready.
- out_valid = (count != 0) & ~halted.
- Field outputs are always driven from the entry at the read pointer, whether or not it is valid. After reset they read 0. When empty they show stale data; consumers qualify them with out_valid.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged; only possible at count 1, or at count 0 never.
- Pointers increment modulo 2 on push and pop respectively.
- flush (sync):
  - count, read pointer and write pointer go to 0.
  - A push or pop in the same cycle is discarded.
  - Storage contents are not cleared.
  - flush does not clear halted.
- Halt:
  - halted sets on the rising edge where pop occurs with opcode == 4'hF.
  - halted clears only on rst.
  - While halted, in_ready = 0 and out_valid = 0. Buffer contents are frozen.
- Reset (async, rst=1): storage, pointers, count and halted go to 0. Outputs follow immediately: in_ready=1, out_valid=0, all fields 0, count=0, halted=0.
- Reset mid-handshake: any in-flight push or pop is lost; no partial update.

## Timing
- Latency: an instruction pushed at edge N appears on the outputs with out_valid=1 after edge N. Zero bubble when empty.
- Throughput: one push and one pop per cycle sustained at count 1.
- Full (count 2): in_ready low. A pop at edge N raises in_ready after edge N, so the next push lands at edge N+1.
- Empty: out_valid low, and out_ready is ignored.
- halted asserts in the cycle after the HALT pop edge. A push in the same edge as the HALT pop is still accepted, then frozen.
- All outputs are glitch-free functions of registers; imm4 is stable for the whole cycle the sign extender samples it.

## Test plan
- Reset, then push instr 16'h1238 at pc 0 with out_ready=0 → next cycle: out_valid=1, opcode=1, rd=2, rs=3, imm4=4'h8, count=1.
- Push 16'hA001 and 16'hB002 with out_ready=0 → count=2, in_ready=0. A third push held valid is not accepted. Raise out_ready → pops in order A001 then B002, and the third instruction enters after in_ready rises.
- Steady stream with in_valid=out_ready=1 for 8 cycles, PCs 0..7 → count stays 1, output PCs 0..7 in order, one per cycle, no gaps.
- Count 2, assert flush together with in_valid=1 → count=0, out_valid=0 next cycle, and the pushed word is dropped.
- Push 16'hF000, pop it → halted=1, in_ready=0 and out_valid=0 thereafter. Pulse rst → halted=0, in_ready=1.
- Assert rst asynchronously mid-cycle at count 2 → outputs go to reset values before the next clock edge.

Source files
------------

// File: rtl/instr_decode_buffer.sv
// Two-entry in-order instruction buffer between fetch and decode.
// Presents the head entry split into register fields and a 4-bit immediate,
// supports synchronous flush and latches a halt when a HALT (opcode F) pops.
module instr_decode_buffer #(
  parameter int INSTR_W = 16,
  parameter int PC_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               flush,
  output logic [PC_W-1:0]    out_pc,
  output logic [3:0]         opcode,
  output logic [3:0]         rd,
  output logic [3:0]         rs,
  output logic [3:0]         rt,
  output logic [3:0]         imm4,
  output logic [1:0]         count,
  output logic               halted
);

  localparam logic [3:0] OP_HALT = 4'hF;

  logic [INSTR_W-1:0] instr_q [2];
  logic [INSTR_W-1:0] instr_d [2];
  logic [PC_W-1:0]    pc_q    [2];
  logic [PC_W-1:0]    pc_d    [2];
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         count_q,  count_d;
  logic               halted_q, halted_d;

  logic               push;
  logic               pop;
  logic [INSTR_W-1:0] head_instr;

  // Handshake and head-entry outputs, all derived from registered state
  always_comb begin
    in_ready   = (count_q != 2'd2) & ~halted_q;
    out_valid  = (count_q != 2'd0) & ~halted_q;
    push       = in_valid & in_ready;
    pop        = out_valid & out_ready;
    head_instr = instr_q[rd_ptr_q];
    out_pc     = pc_q[rd_ptr_q];
    opcode     = head_instr[15:12];
    rd         = head_instr[11:8];
    rs         = head_instr[7:4];
    rt         = head_instr[3:0];
    imm4       = head_instr[3:0];
    count      = count_q;
    halted     = halted_q;
  end

  // Next-state: storage write, pointer/count update, flush and halt capture.
  // A flush discards any same-cycle push or pop, so a HALT popped under
  // flush does not set halted.
  always_comb begin
    instr_d  = instr_q;
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    halted_d = halted_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        instr_d[wr_ptr_q] = in_instr;
        pc_d[wr_ptr_q]    = in_pc;
        wr_ptr_d          = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
        if (head_instr[15:12] == OP_HALT) begin
          halted_d = 1'b1;
        end
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      halted_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        instr_q[i] <= instr_d[i];
        pc_q[i]    <= pc_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      halted_q <= halted_d;
    end
  end

endmodule

// File: tb/tb_instr_decode_buffer.sv
// Bench for instr_decode_buffer: queue-based reference model, per-cycle
// compare process, directed scenarios with literal expectations, random phase.
module tb_instr_decode_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_instr;
  logic [15:0] in_pc;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic        flush;
  logic [15:0] out_pc;
  logic [3:0]  opcode, rd, rs, rt, imm4;
  logic [1:0]  count;
  logic        halted;

  instr_decode_buffer #(.INSTR_W(16), .PC_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
    .in_pc(in_pc), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .flush(flush), .out_pc(out_pc), .opcode(opcode),
    .rd(rd), .rs(rs), .rt(rt), .imm4(imm4), .count(count), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } ent_t;

  ent_t mq[$];
  bit   mhalt;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: an ordered queue of at most two entries plus a halt flag
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mhalt = 1'b0;
    end else begin
      bit pu, po;
      pu = in_valid && (mq.size() < 2) && !mhalt;
      po = out_ready && (mq.size() > 0) && !mhalt;
      if (flush) begin
        mq.delete();
      end else begin
        if (po) begin
          if (mq[0].instr[15:12] == 4'hF) mhalt = 1'b1;
          void'(mq.pop_front());
        end
        if (pu) mq.push_back({in_instr, in_pc});
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (!rst) begin
      bit ev;
      ev = (mq.size() > 0) && !mhalt;
      chk("in_ready",  {31'd0, in_ready},  {31'd0, (mq.size() < 2) && !mhalt});
      chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
      chk("count",     {30'd0, count},     mq.size());
      chk("halted",    {31'd0, halted},    {31'd0, mhalt});
      if (ev) begin
        chk("out_pc", {16'd0, out_pc}, {16'd0, mq[0].pc});
        chk("opcode", {28'd0, opcode}, {28'd0, mq[0].instr[15:12]});
        chk("rd",     {28'd0, rd},     {28'd0, mq[0].instr[11:8]});
        chk("rs",     {28'd0, rs},     {28'd0, mq[0].instr[7:4]});
        chk("rt",     {28'd0, rt},     {28'd0, mq[0].instr[3:0]});
        chk("imm4",   {28'd0, imm4},   {28'd0, mq[0].instr[3:0]});
      end
    end
  end

  task automatic drive(input bit v, input logic [15:0] ins, input logic [15:0] pc,
                       input bit ordy, input bit fl);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_count"},     {30'd0, count},     32'd0);
    chk({tag, "_halted"},    {31'd0, halted},    32'd0);
    chk({tag, "_out_pc"},    {16'd0, out_pc},    32'd0);
    chk({tag, "_fields"},    {16'd0, opcode, rd, rs, rt}, 32'd0);
  endtask

  initial begin
    int waited;
    rst = 1'b1;
    drive(0, '0, '0, 0, 0);
    step();
    chk_reset_vals("reset");
    rst = 1'b0;

    // Single push: fields split and zero-bubble latency
    drive(1, 16'h1238, 16'h0000, 0, 0);
    step();
    drive(0, '0, '0, 0, 0);
    chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_opcode", {28'd0, opcode}, 32'h1);
    chk("t1_rd",     {28'd0, rd},     32'h2);
    chk("t1_rs",     {28'd0, rs},     32'h3);
    chk("t1_imm4",   {28'd0, imm4},   32'h8);
    chk("t1_count",  {30'd0, count},  32'd1);
    drive(0, '0, '0, 1, 0);
    step();
    drive(0, '0, '0, 0, 0);

    // Fill to two, third held off, then drained in order
    drive(1, 16'hA001, 16'h0001, 0, 0);
    step();
    drive(1, 16'hB002, 16'h0002, 0, 0);
    step();
    drive(1, 16'hC003, 16'h0003, 0, 0);
    chk("t2_count_full", {30'd0, count}, 32'd2);
    chk("t2_in_ready_full", {31'd0, in_ready}, 32'd0);
    step();
    chk("t2_count_hold", {30'd0, count}, 32'd2);
    chk("t2_head_a", {16'd0, out_pc}, 32'h1);
    out_ready = 1'b1;
    step();
    chk("t2_head_b", {16'd0, out_pc}, 32'h2);
    chk("t2_opc_b", {28'd0, opcode}, 32'hB);
    chk("t2_in_ready_rise", {31'd0, in_ready}, 32'd1);
    step();
    chk("t2_head_c", {16'd0, out_pc}, 32'h3);
    chk("t2_count_c", {30'd0, count}, 32'd1);
    drive(0, '0, '0, 1, 0);
    step();
    drive(0, '0, '0, 0, 0);
    chk("t2_drained", {30'd0, count}, 32'd0);

    // Sustained stream at count 1
    for (int i = 0; i < 8; i++) begin
      drive(1, {4'(i), 12'h5A5}, 16'(i), 1, 0);
      step();
      chk("t3_count", {30'd0, count}, 32'd1);
      chk("t3_pc", {16'd0, out_pc}, i);
    end
    drive(0, '0, '0, 1, 0);
    step();
    drive(0, '0, '0, 0, 0);
    chk("t3_empty", {30'd0, count}, 32'd0);

    // Flush at count 2 drops the concurrent push
    drive(1, 16'h2111, 16'h0010, 0, 0);
    step();
    drive(1, 16'h3222, 16'h0011, 0, 0);
    step();
    drive(1, 16'h5555, 16'h0012, 0, 1);
    step();
    drive(0, '0, '0, 0, 0);
    chk("t4_count", {30'd0, count}, 32'd0);
    chk("t4_out_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("t4_still_empty", {30'd0, count}, 32'd0);

    // HALT consumption freezes the buffer until reset
    drive(1, 16'hF000, 16'h0020, 0, 0);
    step();
    drive(0, '0, '0, 1, 0);
    step();
    drive(1, 16'h1111, 16'h0021, 1, 0);
    chk("t5_halted", {31'd0, halted}, 32'd1);
    chk("t5_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t5_out_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("t5_frozen", {30'd0, count}, 32'd0);
    drive(0, '0, '0, 0, 0);
    rst = 1'b1;
    #1;
    chk("t5_rst_halted", {31'd0, halted}, 32'd0);
    chk("t5_rst_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    rst = 1'b0;

    // Asynchronous reset mid-cycle at count 2
    drive(1, 16'h4321, 16'h0030, 0, 0);
    step();
    drive(1, 16'h8765, 16'h0031, 0, 0);
    step();
    drive(0, '0, '0, 0, 0);
    chk("t6_pre_count", {30'd0, count}, 32'd2);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("t6");
    step();
    rst = 1'b0;

    // Bounded wait for in_ready (sanity after reset)
    waited = 0;
    while (!in_ready && waited < 10) begin
      step();
      waited++;
    end
    chk("t6_ready_timeout", {31'd0, in_ready}, 32'd1);

    // Random phase; reset whenever the model has halted for a while
    waited = 0;
    for (int c = 0; c < 600; c++) begin
      logic [15:0] ins;
      ins = 16'($urandom);
      if (ins[15:12] == 4'hF && ($urandom_range(0, 3) != 0)) ins[15:12] = 4'h7;
      drive($urandom_range(0, 3) != 0, ins, 16'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
      if (mhalt) waited++;
      if (waited > 3) begin
        waited = 0;
        rst = 1'b1;
        #1;
        chk_reset_vals("rand_rst");
      end
      step();
      rst = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
